// File: rtl/fringe_pkg.sv
// Shared constants for the vibrometer fringe chain: comparator state codes and sample extremes.
package fringe_pkg;

    localparam int unsigned FC_STATE_W = 2;

    localparam logic [FC_STATE_W-1:0] FC_UNKNOWN = 2'b00;
    localparam logic [FC_STATE_W-1:0] FC_LOW     = 2'b01;
    localparam logic [FC_STATE_W-1:0] FC_HIGH    = 2'b10;

    // Extremum finder resets its thresholds to these, which reads as an invalid (lower >= upper) pair.
    localparam logic signed [31:0] SAMPLE_MAX_POS = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] SAMPLE_MAX_NEG = 32'sh8000_0000;

endpackage

// File: rtl/hysteresis_comparator.sv
// Schmitt-trigger next-state logic: returns the next comparator state and a half-fringe pulse.
module hysteresis_comparator
    import fringe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [FC_STATE_W-1:0]        state_i,
    input  logic signed [DATA_WIDTH-1:0] sample_i,
    input  logic signed [DATA_WIDTH-1:0] lower_i,
    input  logic signed [DATA_WIDTH-1:0] upper_i,
    output logic [FC_STATE_W-1:0]        next_state_c_o,
    output logic                         transition_c_o
);

    logic thr_valid_c;
    logic ge_upper_c;
    logic le_lower_c;

    assign thr_valid_c = lower_i < upper_i;
    assign ge_upper_c  = sample_i >= upper_i;
    assign le_lower_c  = sample_i <= lower_i;

    always_comb begin
        next_state_c_o = state_i;
        transition_c_o = 1'b0;
        if (!thr_valid_c) begin
            next_state_c_o = FC_UNKNOWN;
        end else begin
            case (state_i)
                FC_LOW: begin
                    if (ge_upper_c) begin
                        next_state_c_o = FC_HIGH;
                        transition_c_o = 1'b1;
                    end
                end
                FC_HIGH: begin
                    if (le_lower_c) begin
                        next_state_c_o = FC_LOW;
                        transition_c_o = 1'b1;
                    end
                end
                // Leaving UNKNOWN only establishes a reference level; it is never counted.
                default: begin
                    if (ge_upper_c) begin
                        next_state_c_o = FC_HIGH;
                    end else if (le_lower_c) begin
                        next_state_c_o = FC_LOW;
                    end else begin
                        next_state_c_o = FC_UNKNOWN;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/fringe_counter.sv
// Counts hysteresis transitions over windows of 2^N accepted samples and streams one count per window.
// Define FC_SATURATE_EN to make the transition counter saturate instead of wrapping.
module fringe_counter
    import fringe_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned COUNT_WIDTH      = 16
) (
    input  logic                        SYS_aclk,
    input  logic                        SYS_aresetn,
    input  logic [4:0]                  FC_log_count,
    input  logic [AXIS_TDATA_WIDTH-1:0] FC_lower_treshold,
    input  logic [AXIS_TDATA_WIDTH-1:0] FC_upper_treshold,
    output logic [FC_STATE_W-1:0]       FC_state,
    input  logic                        S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                        S_AXIS_tready,
    output logic                        M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    input  logic                        M_AXIS_tready
);

    localparam int unsigned SAMP_CNT_W = 32;

    logic [FC_STATE_W-1:0]       state_q, state_d;
    logic [COUNT_WIDTH-1:0]      trans_cnt_q, trans_cnt_d;
    logic [SAMP_CNT_W-1:0]       samp_cnt_q, samp_cnt_d;
    logic [4:0]                  log_n_q, log_n_d;
    logic                        m_valid_q, m_valid_d;
    logic [AXIS_TDATA_WIDTH-1:0] m_data_q, m_data_d;

    logic [FC_STATE_W-1:0]  comp_next_c;
    logic                   comp_trans_c;
    logic                   accept_c;
    logic [4:0]             log_n_eff_c;
    logic                   window_last_c;
    logic [COUNT_WIDTH-1:0] trans_inc_c;

    hysteresis_comparator #(
        .DATA_WIDTH(AXIS_TDATA_WIDTH)
    ) u_cmp (
        .state_i        (state_q),
        .sample_i       ($signed(S_AXIS_tdata)),
        .lower_i        ($signed(FC_lower_treshold)),
        .upper_i        ($signed(FC_upper_treshold)),
        .next_state_c_o (comp_next_c),
        .transition_c_o (comp_trans_c)
    );

    // Input stalls only while a finished window result is waiting and refused.
    assign S_AXIS_tready = ~(m_valid_q & ~M_AXIS_tready);
    assign accept_c      = S_AXIS_tvalid & S_AXIS_tready;

    assign FC_state      = state_q;
    assign M_AXIS_tvalid = m_valid_q;
    assign M_AXIS_tdata  = m_data_q;

    always_comb begin
        state_d     = state_q;
        trans_cnt_d = trans_cnt_q;
        samp_cnt_d  = samp_cnt_q;
        log_n_d     = log_n_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;

        // The first sample of a window uses the live exponent; later samples use the latched copy.
        log_n_eff_c   = (samp_cnt_q == '0) ? FC_log_count : log_n_q;
        window_last_c = samp_cnt_q == ((SAMP_CNT_W'(1) << log_n_eff_c) - SAMP_CNT_W'(1));

`ifdef FC_SATURATE_EN
        trans_inc_c = (comp_trans_c && (trans_cnt_q != '1)) ? trans_cnt_q + COUNT_WIDTH'(1) : trans_cnt_q;
`else
        trans_inc_c = trans_cnt_q + COUNT_WIDTH'(comp_trans_c);
`endif

        if (M_AXIS_tready) begin
            m_valid_d = 1'b0;
        end

        if (accept_c) begin
            state_d = comp_next_c;
            log_n_d = log_n_eff_c;
            if (window_last_c) begin
                m_valid_d   = 1'b1;
                m_data_d    = AXIS_TDATA_WIDTH'(trans_inc_c);
                trans_cnt_d = '0;
                samp_cnt_d  = '0;
            end else begin
                trans_cnt_d = trans_inc_c;
                samp_cnt_d  = samp_cnt_q + SAMP_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
        if (!SYS_aresetn) begin
            state_q     <= FC_UNKNOWN;
            trans_cnt_q <= '0;
            samp_cnt_q  <= '0;
            log_n_q     <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            trans_cnt_q <= trans_cnt_d;
            samp_cnt_q  <= samp_cnt_d;
            log_n_q     <= log_n_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
        end
    end

endmodule

// File: tb/tb_fringe_counter.sv
// Self-checking bench for fringe_counter: directed scenarios plus randomized traffic against a rule-level model.
module tb_fringe_counter;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic                 clk;
    logic                 rst_n;
    logic [4:0]           log_n;
    logic signed [DW-1:0] lo_s;
    logic signed [DW-1:0] hi_s;
    logic [1:0]           fc_state;
    logic                 s_tvalid;
    logic signed [DW-1:0] s_tdata;
    logic                 s_tready;
    logic                 m_tvalid;
    logic [DW-1:0]        m_tdata;
    logic                 m_tready;

    int ncmp  = 0;
    int nfail = 0;

    // Reference model: comparator level (0 unknown, 1 low, 2 high), window bookkeeping, pending output.
    int m_st  = 0;
    int m_cnt = 0;
    int m_sc  = 0;
    int m_nl  = 0;
    bit m_ov  = 0;
    int m_od  = 0;

    fringe_counter #(
        .AXIS_TDATA_WIDTH(DW),
        .COUNT_WIDTH     (CW)
    ) dut (
        .SYS_aclk          (clk),
        .SYS_aresetn       (rst_n),
        .FC_log_count      (log_n),
        .FC_lower_treshold (lo_s),
        .FC_upper_treshold (hi_s),
        .FC_state          (fc_state),
        .S_AXIS_tvalid     (s_tvalid),
        .S_AXIS_tdata      (s_tdata),
        .S_AXIS_tready     (s_tready),
        .M_AXIS_tvalid     (m_tvalid),
        .M_AXIS_tdata      (m_tdata),
        .M_AXIS_tready     (m_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic bump();
`ifdef FC_SATURATE_EN
        if (m_cnt < CNT_MAX) m_cnt++;
`else
        m_cnt = (m_cnt + 1) % (CNT_MAX + 1);
`endif
    endtask

    task automatic model_sample(input logic signed [DW-1:0] d);
        if (m_sc == 0) m_nl = int'(log_n);
        if (!(lo_s < hi_s)) begin
            m_st = 0;
        end else if (d >= hi_s) begin
            if (m_st == 1) bump();
            m_st = 2;
        end else if (d <= lo_s) begin
            if (m_st == 2) bump();
            m_st = 1;
        end
        m_sc++;
        if (longint'(m_sc) == (longint'(1) << m_nl)) begin
            m_od  = m_cnt;
            m_ov  = 1'b1;
            m_cnt = 0;
            m_sc  = 0;
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_sc = 0; m_nl = 0; m_ov = 1'b0; m_od = 0;
    endtask

    // One clock cycle: drive, check ready before the edge, advance model, check registered outputs after it.
    task automatic cyc(input bit v, input logic signed [DW-1:0] d, input bit r);
        bit erdy;
        s_tvalid = v;
        s_tdata  = d;
        m_tready = r;
        #1;
        erdy = !(m_ov && !r);
        check("s_tready", 32'(s_tready), 32'(erdy));
        if (m_ov && r) m_ov = 1'b0;
        if (v && erdy) model_sample(d);
        @(posedge clk);
        #1;
        check("fc_state", 32'(fc_state), 32'(m_st));
        check("m_tvalid", 32'(m_tvalid), 32'(m_ov));
        if (m_ov) check("m_tdata", m_tdata, 32'(m_od));
    endtask

    // Asynchronous reset placed between clock edges.
    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_state", 32'(fc_state), 32'd0);
        check("rst_tready", 32'(s_tready), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int basic_seq[8] = '{0, 150, 0, -150, 150, -150, 0, 0};
        rst_n    = 1'b0;
        log_n    = 5'd0;
        lo_s     = -32'sd100;
        hi_s     = 32'sd100;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b1;

        #12;
        check("reset_state", 32'(fc_state), 32'd0);
        check("reset_tvalid", 32'(m_tvalid), 32'd0);
        check("reset_tdata", m_tdata, 32'd0);
        check("reset_tready", 32'(s_tready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic window
        log_n = 5'd3;
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'(basic_seq[i]), 1'b1);
        check("basic_tvalid", 32'(m_tvalid), 32'd1);
        check("basic_tdata", m_tdata, 32'd3);
        cyc(1'b0, '0, 1'b1);

        // Hysteresis: samples never reach either threshold
        async_reset();
        log_n = 5'd4;
        for (int i = 0; i < 16; i++) cyc(1'b1, (i % 2 == 0) ? -32'sd99 : 32'sd99, 1'b1);
        check("hyst_tdata", m_tdata, 32'd0);
        check("hyst_state", 32'(fc_state), 32'd0);
        cyc(1'b0, '0, 1'b1);

        // Invalid thresholds
        lo_s  = 32'sd50;
        hi_s  = 32'sd50;
        log_n = 5'd2;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, (i % 2 == 0) ? 32'sd1000 : -32'sd1000, 1'b1);
            if (i % 4 == 3) check("inval_tdata", m_tdata, 32'd0);
        end
        check("inval_state", 32'(fc_state), 32'd0);
        cyc(1'b0, '0, 1'b1);

        // Backpressure at N = 0
        async_reset();
        lo_s  = -32'sd100;
        hi_s  = 32'sd100;
        log_n = 5'd0;
        cyc(1'b1, 32'sd150, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, -32'sd150, 1'b0);
        check("bp_held_tdata", m_tdata, 32'd0);
        for (int i = 0; i < 6; i++) cyc(1'b1, (i % 2 == 0) ? -32'sd150 : 32'sd150, 1'b1);
        cyc(1'b0, '0, 1'b1);

        // Overflow: 31 counted transitions in one 32-sample window
        async_reset();
        log_n = 5'd5;
        for (int i = 0; i < 32; i++) cyc(1'b1, (i % 2 == 0) ? 32'sd1000 : -32'sd1000, 1'b1);
        check("ovf_tdata", m_tdata, 32'd15);
        cyc(1'b0, '0, 1'b1);

        // Reset mid-window, then a clean window counts from zero
        log_n = 5'd3;
        for (int i = 0; i < 3; i++) cyc(1'b1, (i % 2 == 0) ? 32'sd1000 : -32'sd1000, 1'b1);
        async_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'(basic_seq[i]), 1'b1);
        check("post_rst_tdata", m_tdata, 32'd3);
        cyc(1'b0, '0, 1'b1);

        // Randomized traffic with shifting thresholds, window lengths and backpressure
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) begin
                if ($urandom_range(7, 0) == 0) begin
                    lo_s = 32'($urandom_range(200, 0));
                    hi_s = lo_s - 32'($urandom_range(50, 0));
                end else begin
                    lo_s = -32'($urandom_range(200, 0));
                    hi_s = 32'($urandom_range(200, 1));
                end
            end
            if ($urandom_range(19, 0) == 0) log_n = 5'($urandom_range(4, 0));
            cyc(1'($urandom_range(3, 0) != 0), 32'(int'($urandom_range(600, 0)) - 300),
                1'($urandom_range(2, 0) != 0));
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
